// File: rtl/muldiv_pkg.sv
// Shared op-code constants, FSM state encoding and op-class helpers for the
// multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  function automatic logic is_signed_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divider on operand magnitudes; exposes the next-step
// quotient/remainder so the caller can apply sign fixup on the final step.
module muldiv_div_core #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_signed,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_last,
  output logic [XLEN-1:0] o_quo_next,
  output logic [XLEN-1:0] o_rem_next
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] quo_reg, rem_reg, dvs_reg;
  logic [CW-1:0]   cnt_reg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   shifted;
  logic            ge;

  assign a_mag = (i_signed && i_a[XLEN-1]) ? -i_a : i_a;
  assign b_mag = (i_signed && i_b[XLEN-1]) ? -i_b : i_b;

  // When the trial subtraction succeeds the difference is below the divisor,
  // so the low XLEN bits of the subtraction are exact.
  assign shifted    = {rem_reg, quo_reg[XLEN-1]};
  assign ge         = shifted >= {1'b0, dvs_reg};
  assign o_rem_next = shifted[XLEN-1:0] - (ge ? dvs_reg : '0);
  assign o_quo_next = {quo_reg[XLEN-2:0], ge};
  assign o_last     = (cnt_reg == CW'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      quo_reg <= '0;
      rem_reg <= '0;
      dvs_reg <= '0;
      cnt_reg <= '0;
    end else if (i_load) begin
      quo_reg <= a_mag;
      rem_reg <= '0;
      dvs_reg <= b_mag;
      cnt_reg <= CW'(XLEN);
    end else if (i_step) begin
      quo_reg <= o_quo_next;
      rem_reg <= o_rem_next;
      if (cnt_reg != '0) cnt_reg <= cnt_reg - CW'(1);
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M-style multiply/divide unit: pipelined multiplier, iterative divider,
// and the IDLE/MUL/DIV/DONE control FSM.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_A,
  input  logic [XLEN-1:0] i_B,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int PIPE_N = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_reg, state_next;
  logic [2:0]      op_reg;
  logic            q_neg_reg, r_neg_reg;
  logic [1:0]      mul_cnt_reg;
  logic [XLEN-1:0] result_reg, result_next;
  logic            start_ok, mul_last, div_last;
  logic            div_zero, div_ovf, div_special;
  logic [XLEN-1:0] div_special_val, quo_next, rem_next, div_res, mul_res;
  logic            a_ext_hi, b_ext_hi;
  logic [2*XLEN-1:0] a_wide, b_wide, mul_prod, mul_src;
  logic [2*XLEN-1:0] mul_pipe_reg [PIPE_N];
  logic [2:0]      mul_op;

  assign start_ok = i_start && (state_reg == S_IDLE);

  // Zero/overflow divides resolve in one cycle from the raw inputs.
  assign div_zero        = (i_B == '0);
  assign div_ovf         = is_signed_div(i_op) && (i_A == XMIN) && (i_B == '1);
  assign div_special     = div_zero || div_ovf;
  assign div_special_val = div_zero ? (is_rem_op(i_op) ? i_A : '1)
                                    : (is_rem_op(i_op) ? '0 : i_A);

  // Extending each operand by its signedness makes one 2XLEN multiply serve all four ops.
  assign a_ext_hi = ((i_op == OP_MULH) || (i_op == OP_MULHSU)) && i_A[XLEN-1];
  assign b_ext_hi = (i_op == OP_MULH) && i_B[XLEN-1];
  assign a_wide   = {{XLEN{a_ext_hi}}, i_A};
  assign b_wide   = {{XLEN{b_ext_hi}}, i_B};
  assign mul_prod = a_wide * b_wide;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < PIPE_N; k++) mul_pipe_reg[k] <= '0;
    end else begin
      if (start_ok && is_mul_op(i_op)) mul_pipe_reg[0] <= mul_prod;
      for (int k = 1; k < PIPE_N; k++) mul_pipe_reg[k] <= mul_pipe_reg[k-1];
    end
  end

  assign mul_src  = (MUL_LAT == 1) ? mul_prod : mul_pipe_reg[PIPE_N-1];
  assign mul_op   = (MUL_LAT == 1) ? i_op : op_reg;
  assign mul_res  = (mul_op == OP_MUL) ? mul_src[XLEN-1:0] : mul_src[2*XLEN-1:XLEN];
  assign mul_last = (mul_cnt_reg == 2'(MUL_LAT - 2));

  muldiv_div_core #(.XLEN(XLEN)) u_div_core (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (start_ok && !is_mul_op(i_op) && !div_special),
    .i_step     (state_reg == S_DIV),
    .i_signed   (is_signed_div(i_op)),
    .i_a        (i_A),
    .i_b        (i_B),
    .o_last     (div_last),
    .o_quo_next (quo_next),
    .o_rem_next (rem_next)
  );

  assign div_res = is_rem_op(op_reg) ? (r_neg_reg ? -rem_next : rem_next)
                                     : (q_neg_reg ? -quo_next : quo_next);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= S_IDLE;
      op_reg      <= '0;
      q_neg_reg   <= 1'b0;
      r_neg_reg   <= 1'b0;
      mul_cnt_reg <= '0;
      result_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (start_ok) begin
        op_reg      <= i_op;
        q_neg_reg   <= is_signed_div(i_op) && (i_A[XLEN-1] ^ i_B[XLEN-1]);
        r_neg_reg   <= is_signed_div(i_op) && i_A[XLEN-1];
        mul_cnt_reg <= '0;
      end else if (state_reg == S_MUL) begin
        mul_cnt_reg <= mul_cnt_reg + 2'd1;
      end
      if (state_next == S_DONE) result_reg <= result_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: if (i_start) begin
        if (is_mul_op(i_op)) state_next = (MUL_LAT == 1) ? S_DONE : S_MUL;
        else                 state_next = div_special ? S_DONE : S_DIV;
      end
      S_MUL:  if (i_flush) state_next = S_IDLE; else if (mul_last) state_next = S_DONE;
      S_DIV:  if (i_flush) state_next = S_IDLE; else if (div_last) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    result_next = result_reg;
    unique case (state_reg)
      S_IDLE:  result_next = is_mul_op(i_op) ? mul_res : div_special_val;
      S_MUL:   result_next = mul_res;
      S_DIV:   result_next = div_res;
      default: result_next = result_reg;
    endcase
  end

  always_comb begin
    o_busy = (state_reg != S_IDLE);
    o_done = (state_reg == S_DONE);
  end

  assign o_result = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;

  logic        i_clk = 1'b0;
  logic        i_rst, i_start, i_flush;
  logic [2:0]  i_op;
  logic [31:0] i_A, i_B;
  logic        o_busy, o_done;
  logic [31:0] o_result;

  muldiv_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_op(i_op),
    .i_A(i_A), .i_B(i_B), .i_flush(i_flush),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          done_cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          total = 0, bad = 0, flush_aborts = 0;
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return MUL_LAT;
    if (b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever the DUT signals completion.
  always @(negedge i_clk) begin
    if (!i_rst && o_done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=%h required=no_done (cycle %0d)", o_result, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", 64'(o_result), 64'(mon_e.res));
        check("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
        last_res = mon_e.res;
        $display("txn op=%0d A=%h B=%h result=%h expected=%h cycle=%0d",
                 mon_e.op, mon_e.a, mon_e.b, o_result, mon_e.res, cyc);
      end
    end
  end

  // Called at a negedge with the DUT idle; leaves at the following negedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic flush_too, input logic use_exp, input logic [31:0] exp_val);
    exp_t e;
    e.op = op; e.a = a; e.b = b;
    e.res = use_exp ? exp_val : ref_result(op, a, b);
    e.done_cyc = cyc + ref_latency(op, a, b);
    exp_q.push_back(e);
    i_start = 1'b1; i_op = op; i_A = a; i_B = b; i_flush = flush_too;
    @(negedge i_clk);
    i_start = 1'b0; i_flush = 1'b0;
  endtask

  // Drives junk (including stray starts) while busy; optionally flushes at cycle flush_cyc.
  task automatic run_until_idle(input int flush_cyc);
    int   n = 0;
    logic aborted;
    while (o_busy && n < 200) begin
      aborted = 1'b0;
      i_start = 1'($urandom_range(1));
      i_op    = 3'($urandom_range(7));
      i_A     = $urandom;
      i_B     = $urandom;
      if (cyc == flush_cyc) begin
        i_flush = 1'b1;
        if (exp_q.size() > 0 && cyc < exp_q[$].done_cyc) begin
          void'(exp_q.pop_back());
          aborted = 1'b1;
          flush_aborts++;
        end
      end
      @(negedge i_clk);
      i_flush = 1'b0;
      if (aborted) begin
        check("flush_busy", 64'(o_busy), 64'(0));
        check("flush_result_hold", 64'(o_result), 64'(last_res));
      end
      n++;
    end
    i_start = 1'b0;
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL idle_timeout actual=busy required=idle (cycle %0d)", cyc);
    end
  endtask

  int          t0, fa0;
  logic [2:0]  rop;
  logic [31:0] ra, rb;

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_flush = 1'b0; i_op = '0; i_A = '0; i_B = '0;
    repeat (3) @(negedge i_clk);
    check("reset_busy", 64'(o_busy), 64'(0));
    check("reset_done", 64'(o_done), 64'(0));
    check("reset_result", 64'(o_result), 64'(0));
    i_rst = 1'b0;

    // Directed corners; the first also asserts flush alongside the start.
    issue(3'd1, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h40000000); run_until_idle(-1);
    issue(3'd0, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h00000000); run_until_idle(-1);
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF); run_until_idle(-1);
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFE); run_until_idle(-1);
    issue(3'd4, 32'hFFFFFFF9, 32'd2,        1'b0, 1'b1, 32'hFFFFFFFD); run_until_idle(-1);
    issue(3'd6, 32'hFFFFFFF9, 32'd2,        1'b0, 1'b1, 32'hFFFFFFFF); run_until_idle(-1);
    issue(3'd5, 32'd100,      32'd7,        1'b0, 1'b1, 32'd14);       run_until_idle(-1);
    issue(3'd5, 32'd5,        32'd0,        1'b0, 1'b1, 32'hFFFFFFFF); run_until_idle(-1);
    issue(3'd7, 32'd5,        32'd0,        1'b0, 1'b1, 32'd5);        run_until_idle(-1);
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000); run_until_idle(-1);
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000000); run_until_idle(-1);

    // Flush ten cycles into a divide, then a fresh divide right away.
    issue(3'd5, 32'd12345, 32'd11, 1'b0, 1'b1, 32'd1122); run_until_idle(-1);
    fa0 = flush_aborts;
    t0 = cyc;
    issue(3'd4, 32'd1000, 32'd3, 1'b0, 1'b1, 32'd333);
    run_until_idle(t0 + 10);
    check("flush_aborted", 64'(flush_aborts - fa0), 64'(1));
    check("flush_idle_cycle", 64'(cyc), 64'(t0 + 11));
    issue(3'd5, 32'd1000, 32'd3, 1'b0, 1'b1, 32'd333); run_until_idle(-1);

    // Asynchronous reset in the middle of a divide.
    issue(3'd4, 32'd999, 32'd7, 1'b0, 1'b0, 32'd0);
    repeat (3) @(negedge i_clk);
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    check("midop_reset_busy", 64'(o_busy), 64'(0));
    check("midop_reset_done", 64'(o_done), 64'(0));
    check("midop_reset_result", 64'(o_result), 64'(0));
    exp_q.delete();
    last_res = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    issue(3'd3, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'd0); run_until_idle(-1);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 2400; i++) begin
      rop = 3'($urandom_range(7));
      ra  = pick_operand();
      rb  = pick_operand();
      t0  = cyc;
      issue(rop, ra, rb, ($urandom_range(15) == 0), 1'b0, 32'd0);
      run_until_idle(($urandom_range(9) == 0) ? t0 + 1 + int'($urandom_range(5)) : -1);
    end

    repeat (3) @(negedge i_clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32: operand and result width, any even value 8..64.
REQ-002 Parameter MUL_LAT, default 2: cycles from accepted start to o_done for multiply ops, range 1..4.
REQ-003 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  in  1  asynchronous, active-high reset.
REQ-005 i_start  in  1  request; accepted only in a cycle where o_busy=0.
REQ-006 i_op  in  3  operation, RV32M funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 i_A  in  XLEN  rs1 operand (multiplicand / dividend).
REQ-008 i_B  in  XLEN  rs2 operand (multiplier / divisor).
REQ-009 i_flush  in  1  abort of the in-flight operation.
REQ-010 o_busy  out  1  high in every state except IDLE.
REQ-011 o_done  out  1  one-cycle pulse; o_result is valid in that cycle.
REQ-012 o_result  out  XLEN  result; holds its value until the next o_done.

Function
REQ-013 FSM states SHALL be IDLE, MUL, DIV and DONE; o_done=1 exactly in DONE, and DONE always returns to IDLE.
REQ-014 Operands and op SHALL be registered when a start is accepted in cycle t; input changes after t have no effect on the result.
REQ-015 i_start while o_busy=1 SHALL be ignored, with no queuing and no side effects.
REQ-016 Multiply: IDLE->MUL at t; DONE at cycle t+MUL_LAT; MUL_LAT=1 goes IDLE->DONE directly.
REQ-017 MUL SHALL return product bits [XLEN-1:0]; MULH signed x signed bits [2XLEN-1:XLEN]; MULHSU signed A x unsigned B upper half; MULHU unsigned x unsigned upper half.
REQ-018 Divide by zero SHALL skip DIV and reach DONE at t+1: DIV/DIVU result all ones, REM/REMU result = i_A.
REQ-019 Signed overflow (DIV/REM, A=-2^(XLEN-1), B=-1) SHALL reach DONE at t+1: DIV result = A, REM result = 0.
REQ-020 Other divides SHALL use a radix-2 restoring iteration on operand magnitudes: DIV state for exactly XLEN cycles (t+1..t+XLEN), DONE at t+XLEN+1.
REQ-021 Sign fixup SHALL be applied on the transition into DONE: quotient negated when operand signs differ (signed ops), remainder takes the sign of the dividend; unsigned ops take no fixup.
REQ-022 An iteration counter of ceil(log2(XLEN))+1 bits SHALL load XLEN on entry to DIV and decrement each cycle; exit on reaching 1, with no wrap.
REQ-023 i_flush=1 in MUL or DIV SHALL force IDLE next cycle with no o_done, and o_result unchanged; i_flush in IDLE or DONE has no effect, and an o_done already in progress still pulses.
REQ-024 i_flush and i_start in the same IDLE cycle: the start is accepted.
REQ-025 The earliest next start is the cycle after DONE, so back-to-back throughput is one op per latency+1 cycles.

Reset
REQ-026 i_rst=1 SHALL immediately force state IDLE, o_busy=0, o_done=0, o_result=0, and clear the counter and operand registers, including mid-operation.
REQ-027 The first start SHALL be accepted in the first rising edge after i_rst deasserts.

Structure
REQ-028 Package muldiv_pkg SHALL hold the op-code constants (OP_MUL..OP_REMU) and the state encoding; the existing alu decoder maps opcodes 10..17 onto these.
REQ-029 The iterative divider (magnitude registers, partial remainder, counter) SHALL be sub-module muldiv_div_core; the multiplier and the FSM remain in muldiv_unit.
REQ-030 The multiply pipeline SHALL be MUL_LAT register stages on a 2XLEN-bit signed product of sign/zero-extended (XLEN+1)-bit operands.

Verification (XLEN=32, MUL_LAT=2)
REQ-031 MULH A=0x80000000, B=0x80000000, start at t -> o_done at t+2, o_result=0x40000000; same operands with MUL -> 0x00000000.
REQ-032 MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
REQ-033 DIV A=0xFFFFFFF9 (-7), B=2 -> o_done at t+33, result 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14.
REQ-034 DIVU 5/0 -> o_done at t+1, result 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> t+1, 0x80000000; REM same operands -> 0.
REQ-035 DIV started at t, i_flush at t+10 -> o_busy=0 at t+11 and no o_done; a start at t+11 completes normally; i_rst asserted at t+5 of a DIV -> outputs zero immediately.
REQ-036 A start pulse during busy -> ignored, with the result of the first op unchanged; scoreboard 10k random ops per i_op value against a reference model, including 0, -1 and MIN operands.
